multicycle_control: RTL and testbench

//  Multi-cycle main controller for the RV32I core: sequences one shared ALU and one unified

---
 rtl/rv_ctrl_pkg.sv | 59 +++++
 rtl/mc_ctrl_outdec.sv | 79 +++++++
 rtl/multicycle_control.sv | 128 ++++++++++++
 tb/tb_multicycle_control.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, ALU/operand selects,
// FSM states and the packed control word driven onto the datapath.
package rv_ctrl_pkg;

   localparam logic [6:0] OPCODE_R   = 7'b0110011;
   localparam logic [6:0] OPCODE_I   = 7'b0010011;
   localparam logic [6:0] OPCODE_L   = 7'b0000011;
   localparam logic [6:0] OPCODE_S   = 7'b0100011;
   localparam logic [6:0] OPCODE_B   = 7'b1100011;
   localparam logic [6:0] OPCODE_LUI = 7'b0110111;

   localparam logic [2:0] ALU_OP_ADD    = 3'b000;
   localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
   localparam logic [2:0] ALU_OP_R      = 3'b010;
   localparam logic [2:0] ALU_OP_I      = 3'b011;
   localparam logic [2:0] ALU_OP_LUI    = 3'b100;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC     = 4'd3,
      ST_WB_ALU   = 4'd4,
      ST_MEM_ADDR = 4'd5,
      ST_MEM_RD   = 4'd6,
      ST_WB_MEM   = 4'd7,
      ST_MEM_WR   = 4'd8,
      ST_BRANCH   = 4'd9
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = 15'd0;

   function automatic logic is_supported(input logic [6:0] opcode);
      case (opcode)
         OPCODE_R, OPCODE_I, OPCODE_L, OPCODE_S, OPCODE_B, OPCODE_LUI: is_supported = 1'b1;
         default:                                                       is_supported = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode from FSM state (opcode selects the EXEC flavour,
// mem_ready gates the IR/PC update in FETCH).
module mc_ctrl_outdec
   import rv_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [6:0] i_opcode,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctrl
);

   // Per-state control word; anything not set stays 0.
   always_comb begin
      o_ctrl = CTRL_NONE;
      case (i_state)
         ST_FETCH: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRC_B_FOUR;
            o_ctrl.alu_op    = ALU_OP_ADD;
            if (i_mem_ready) begin
               o_ctrl.ir_write = 1'b1;
               o_ctrl.pc_write = 1'b1;
            end else begin
               o_ctrl.ir_write = 1'b0;
               o_ctrl.pc_write = 1'b0;
            end
         end
         ST_DECODE: begin
            o_ctrl.alu_src_b = SRC_B_IMM;
            o_ctrl.alu_op    = ALU_OP_ADD;
            o_ctrl.illegal   = ~is_supported(i_opcode);
         end
         ST_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            case (i_opcode)
               OPCODE_R: begin
                  o_ctrl.alu_src_b = SRC_B_RS2;
                  o_ctrl.alu_op    = ALU_OP_R;
               end
               OPCODE_I: begin
                  o_ctrl.alu_src_b = SRC_B_IMM;
                  o_ctrl.alu_op    = ALU_OP_I;
               end
               OPCODE_LUI: begin
                  o_ctrl.alu_src_b = SRC_B_IMM;
                  o_ctrl.alu_op    = ALU_OP_LUI;
               end
               default: o_ctrl.alu_op = ALU_OP_ADD;
            endcase
         end
         ST_WB_ALU: o_ctrl.reg_write = 1'b1;
         ST_MEM_ADDR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRC_B_IMM;
            o_ctrl.alu_op    = ALU_OP_ADD;
         end
         ST_MEM_RD: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.iord     = 1'b1;
         end
         ST_WB_MEM: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.iord      = 1'b1;
         end
         ST_BRANCH: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRC_B_RS2;
            o_ctrl.alu_op    = ALU_OP_BRANCH;
            o_ctrl.pc_cond   = 1'b1;
         end
         default: o_ctrl = CTRL_NONE;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main controller: instruction FSM plus retired-instruction counter;
// datapath controls come from mc_ctrl_outdec.
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [6:0]       opcode_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             pc_cond_o,
   output logic             iord_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             ir_write_o,
   output logic             reg_write_o,
   output logic             mem_to_reg_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [2:0]       alu_op_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] instret_o,
   output logic [3:0]       state_o
);

   state_t           r_state;
   state_t           w_next_state;
   logic             w_retire;
   logic [CNT_W-1:0] r_instret;
   ctrl_t            w_ctrl;

   // State register; reset aborts any instruction and drops pending memory requests.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and retirement strobe.
   always_comb begin
      w_next_state = r_state;
      w_retire     = 1'b0;
      case (r_state)
         ST_IDLE:  w_next_state = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready_i) w_next_state = ST_DECODE;
            else             w_next_state = ST_FETCH;
         end
         ST_DECODE: begin
            case (opcode_i)
               OPCODE_R, OPCODE_I, OPCODE_LUI: w_next_state = ST_EXEC;
               OPCODE_L, OPCODE_S:             w_next_state = ST_MEM_ADDR;
               OPCODE_B:                       w_next_state = ST_BRANCH;
               default:                        w_next_state = ST_FETCH;
            endcase
         end
         ST_EXEC: w_next_state = ST_WB_ALU;
         ST_WB_ALU: begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
         end
         ST_MEM_ADDR: begin
            if (opcode_i == OPCODE_S) w_next_state = ST_MEM_WR;
            else                      w_next_state = ST_MEM_RD;
         end
         ST_MEM_RD: begin
            if (mem_ready_i) w_next_state = ST_WB_MEM;
            else             w_next_state = ST_MEM_RD;
         end
         ST_WB_MEM: begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
         end
         ST_MEM_WR: begin
            if (mem_ready_i) begin
               w_next_state = ST_FETCH;
               w_retire     = 1'b1;
            end else begin
               w_next_state = ST_MEM_WR;
               w_retire     = 1'b0;
            end
         end
         ST_BRANCH: begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Retired-instruction counter, wraps silently.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_instret <= {CNT_W{1'b0}};
      end else if (w_retire) begin
         r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_instret <= r_instret;
      end
   end

   mc_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_opcode    (opcode_i),
      .i_mem_ready (mem_ready_i),
      .o_ctrl      (w_ctrl)
   );

   assign pc_write_o   = w_ctrl.pc_write;
   assign pc_cond_o    = w_ctrl.pc_cond;
   assign iord_o       = w_ctrl.iord;
   assign mem_read_o   = w_ctrl.mem_read;
   assign mem_write_o  = w_ctrl.mem_write;
   assign ir_write_o   = w_ctrl.ir_write;
   assign reg_write_o  = w_ctrl.reg_write;
   assign mem_to_reg_o = w_ctrl.mem_to_reg;
   assign alu_src_a_o  = w_ctrl.alu_src_a;
   assign alu_src_b_o  = w_ctrl.alu_src_b;
   assign alu_op_o     = w_ctrl.alu_op;
   assign illegal_o    = w_ctrl.illegal;
   assign instret_o    = r_instret;
   assign state_o      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each task queues per-cycle expectations
// (stimulus, state, control word, instret) and checks them at the falling edge.
module tb_multicycle_control;
   import rv_ctrl_pkg::*;

   localparam int W = 4;

   // control word bit order: pc_write pc_cond iord mem_read mem_write ir_write reg_write
   // mem_to_reg src_a src_b[1:0] alu_op[2:0] illegal
   localparam logic [14:0] CW_IDLE      = 15'd0;
   localparam logic [14:0] CW_FETCH_W   = {9'b000100000, 2'b01, 3'b000, 1'b0};
   localparam logic [14:0] CW_FETCH_R   = {9'b100101000, 2'b01, 3'b000, 1'b0};
   localparam logic [14:0] CW_DECODE    = {9'b000000000, 2'b10, 3'b000, 1'b0};
   localparam logic [14:0] CW_DECODE_IL = {9'b000000000, 2'b10, 3'b000, 1'b1};
   localparam logic [14:0] CW_EXEC_R    = {9'b000000001, 2'b00, 3'b010, 1'b0};
   localparam logic [14:0] CW_EXEC_I    = {9'b000000001, 2'b10, 3'b011, 1'b0};
   localparam logic [14:0] CW_EXEC_LUI  = {9'b000000001, 2'b10, 3'b100, 1'b0};
   localparam logic [14:0] CW_WB_ALU    = {9'b000000100, 2'b00, 3'b000, 1'b0};
   localparam logic [14:0] CW_MEM_ADDR  = {9'b000000001, 2'b10, 3'b000, 1'b0};
   localparam logic [14:0] CW_MEM_RD    = {9'b001100000, 2'b00, 3'b000, 1'b0};
   localparam logic [14:0] CW_WB_MEM    = {9'b000000110, 2'b00, 3'b000, 1'b0};
   localparam logic [14:0] CW_MEM_WR    = {9'b001010000, 2'b00, 3'b000, 1'b0};
   localparam logic [14:0] CW_BRANCH    = {9'b010000001, 2'b00, 3'b001, 1'b0};

   localparam logic [6:0] OP_ADD = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef struct {
      logic [6:0]   op;
      logic         rdy;
      logic [3:0]   st;
      logic [14:0]  cw;
      logic [W-1:0] ir;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [6:0]   opcode;
   logic         mem_ready;
   logic         pc_write_o, pc_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
   logic         reg_write_o, mem_to_reg_o, alu_src_a_o, illegal_o;
   logic [1:0]   alu_src_b_o;
   logic [2:0]   alu_op_o;
   logic [W-1:0] instret_o;
   logic [3:0]   state_o;
   logic [14:0]  cw_now;

   exp_t         q[$];
   exp_t         e;
   logic [W-1:0] exp_ir;
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   multicycle_control #(.CNT_W(W)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .opcode_i     (opcode),
      .mem_ready_i  (mem_ready),
      .pc_write_o   (pc_write_o),
      .pc_cond_o    (pc_cond_o),
      .iord_o       (iord_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .ir_write_o   (ir_write_o),
      .reg_write_o  (reg_write_o),
      .mem_to_reg_o (mem_to_reg_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .illegal_o    (illegal_o),
      .instret_o    (instret_o),
      .state_o      (state_o)
   );

   assign cw_now = {pc_write_o, pc_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
                    reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o};

   task automatic push(input logic [6:0] op, input logic rdy, input logic [3:0] st,
                       input logic [14:0] cw);
      exp_t x;
      x.op = op; x.rdy = rdy; x.st = st; x.cw = cw; x.ir = exp_ir;
      q.push_back(x);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b0; exp_ir = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (state_o !== 4'(ST_IDLE) || cw_now !== CW_IDLE || instret_o !== 4'd0) begin
         bad++;
         $display("FAIL reset_hold: state=%0d ctrl=%b instret=%0d expected state=0 ctrl=0 instret=0",
                  state_o, cw_now, instret_o);
      end
      rst_n = 1'b1;
      push(7'd0, 1'b0, ST_IDLE, CW_IDLE);
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL reset_idle: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu();
      push(OP_ADD, 1'b1, ST_FETCH, CW_FETCH_R);
      push(OP_ADD, 1'b1, ST_DECODE, CW_DECODE);
      push(OP_ADD, 1'b1, ST_EXEC, CW_EXEC_R);
      push(OP_ADD, 1'b1, ST_WB_ALU, CW_WB_ALU);
      exp_ir = exp_ir + 4'd1;
      push(OP_LUI, 1'b0, ST_FETCH, CW_FETCH_W);
      push(OP_LUI, 1'b1, ST_FETCH, CW_FETCH_R);
      push(OP_LUI, 1'b0, ST_DECODE, CW_DECODE);
      push(OP_LUI, 1'b0, ST_EXEC, CW_EXEC_LUI);
      push(OP_LUI, 1'b1, ST_WB_ALU, CW_WB_ALU);
      exp_ir = exp_ir + 4'd1;
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL alu: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load();
      push(OP_LW, 1'b1, ST_FETCH, CW_FETCH_R);
      push(OP_LW, 1'b0, ST_DECODE, CW_DECODE);
      push(OP_LW, 1'b1, ST_MEM_ADDR, CW_MEM_ADDR);
      for (int i = 0; i < 3; i++) push(OP_LW, 1'b0, ST_MEM_RD, CW_MEM_RD);
      push(OP_LW, 1'b1, ST_MEM_RD, CW_MEM_RD);
      push(OP_LW, 1'b0, ST_WB_MEM, CW_WB_MEM);
      exp_ir = exp_ir + 4'd1;
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL load: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_branch();
      push(OP_SW, 1'b1, ST_FETCH, CW_FETCH_R);
      push(OP_SW, 1'b1, ST_DECODE, CW_DECODE);
      push(OP_SW, 1'b0, ST_MEM_ADDR, CW_MEM_ADDR);
      push(OP_SW, 1'b0, ST_MEM_WR, CW_MEM_WR);
      push(OP_SW, 1'b1, ST_MEM_WR, CW_MEM_WR);
      exp_ir = exp_ir + 4'd1;
      push(OP_BEQ, 1'b1, ST_FETCH, CW_FETCH_R);
      push(OP_BEQ, 1'b0, ST_DECODE, CW_DECODE);
      push(OP_BEQ, 1'b1, ST_BRANCH, CW_BRANCH);
      exp_ir = exp_ir + 4'd1;
      push(OP_BEQ, 1'b0, ST_FETCH, CW_FETCH_W);
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL store_branch: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      push(OP_JAL, 1'b1, ST_FETCH, CW_FETCH_R);
      push(OP_JAL, 1'b1, ST_DECODE, CW_DECODE_IL);
      push(OP_JAL, 1'b0, ST_FETCH, CW_FETCH_W);
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL illegal: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      push(OP_LW, 1'b1, ST_FETCH, CW_FETCH_R);
      push(OP_LW, 1'b0, ST_DECODE, CW_DECODE);
      push(OP_LW, 1'b0, ST_MEM_ADDR, CW_MEM_ADDR);
      push(OP_LW, 1'b0, ST_MEM_RD, CW_MEM_RD);
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL reset_mid_pre: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #2;
      total++;
      if (state_o !== 4'(ST_IDLE) || cw_now !== CW_IDLE || instret_o !== 4'd0) begin
         bad++;
         $display("FAIL reset_mid: state=%0d ctrl=%b instret=%0d expected state=0 ctrl=0 instret=0",
                  state_o, cw_now, instret_o);
      end
      exp_ir = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      push(OP_LW, 1'b1, ST_IDLE, CW_IDLE);
      push(OP_LW, 1'b0, ST_FETCH, CW_FETCH_W);
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL reset_mid_post: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) begin
         push(OP_ADDI, 1'b1, ST_FETCH, CW_FETCH_R);
         push(OP_ADDI, 1'b0, ST_DECODE, CW_DECODE);
         push(OP_ADDI, 1'b0, ST_EXEC, CW_EXEC_I);
         push(OP_ADDI, 1'b0, ST_WB_ALU, CW_WB_ALU);
         exp_ir = exp_ir + 4'd1;
      end
      push(OP_ADDI, 1'b0, ST_FETCH, CW_FETCH_W);
      while (q.size() > 0) begin
         e = q.pop_front(); opcode = e.op; mem_ready = e.rdy;
         @(negedge clk);
         total++;
         if (state_o !== e.st || cw_now !== e.cw || instret_o !== e.ir) begin
            bad++;
            $display("FAIL wrap: state=%0d ctrl=%b instret=%0d expected state=%0d ctrl=%b instret=%0d",
                     state_o, cw_now, instret_o, e.st, e.cw, e.ir);
         end
         @(posedge clk); #1;
      end
      total++;
      if (instret_o !== 4'd0) begin
         bad++;
         $display("FAIL wrap_final: instret=%0d expected instret=0", instret_o);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store_branch();
      test_illegal();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
